// File: rtl/data_field_sequencer_pkg.sv
// Shared types and constants for the 802.11a DATA-field sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_field_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SERVICE = 3'd2,
        ST_PSDU    = 3'd3,
        ST_TAIL    = 3'd4,
        ST_PAD     = 3'd5
    } state_t;

    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    // Data bits per OFDM symbol for each 802.11a rate.
    localparam logic [7:0] N_DBPS_6M  = 8'd24;
    localparam logic [7:0] N_DBPS_9M  = 8'd36;
    localparam logic [7:0] N_DBPS_12M = 8'd48;
    localparam logic [7:0] N_DBPS_18M = 8'd72;
    localparam logic [7:0] N_DBPS_24M = 8'd96;
    localparam logic [7:0] N_DBPS_36M = 8'd144;
    localparam logic [7:0] N_DBPS_48M = 8'd192;
    localparam logic [7:0] N_DBPS_54M = 8'd216;

endpackage

// File: rtl/data_field_sequencer_if.sv
// Bundle of MAC byte, scrambler and encoder-side signals of the DATA-field sequencer.
// Latency: n/a (wiring only).
// Backpressure: byte side is a ready strobe with valid; encoder side has none.
interface data_field_sequencer_if #(parameter int LENGTH_W = 12);

    logic                Start;
    logic [LENGTH_W-1:0] Length;
    logic [7:0]          N_DBPS;
    logic [7:0]          Byte;
    logic                Byte_Valid;
    logic                Byte_Ready;
    logic                Scr_Reset;
    logic                Scr_Input;
    logic                Scr_Output;
    logic                Out_Bit;
    logic                Out_Valid;
    logic                Busy;
    logic                Done;
    logic                Error;

    modport master (
        output Start, Length, N_DBPS, Byte, Byte_Valid, Scr_Output,
        input  Byte_Ready, Scr_Reset, Scr_Input, Out_Bit, Out_Valid, Busy, Done, Error
    );

    modport slave (
        input  Start, Length, N_DBPS, Byte, Byte_Valid, Scr_Output,
        output Byte_Ready, Scr_Reset, Scr_Input, Out_Bit, Out_Valid, Busy, Done, Error
    );

endinterface

// File: rtl/data_seq_serializer.sv
// Byte serializer: loads one PSDU byte and shifts it out LSB first, flagging its last bit.
// Latency: bit 0 of a loaded byte is presented the cycle after the load strobe.
// Backpressure: none; load and shift are single-cycle strobes from the sequencer.
module data_seq_serializer (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       load,
    input  logic [7:0] load_dat,
    input  logic       shift,
    output logic       bit_dat,
    output logic       last
);

    logic [7:0] sr_q;
    logic [2:0] idx_q;

    // Load wins over shift so the next byte replaces the finished one without a gap.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else if (load) begin
            sr_q  <= load_dat;
            idx_q <= '0;
        end else if (shift) begin
            sr_q  <= {1'b0, sr_q[7:1]};
            idx_q <= idx_q + 3'd1;
        end
    end

    assign bit_dat = sr_q[0];
    assign last    = (idx_q == 3'd7);

endmodule

// File: rtl/data_field_sequencer.sv
// 802.11a DATA-field sequencer: SERVICE/PSDU/TAIL/PAD bits through an external scrambler.
// Latency: Start -> SEED next cycle, first SERVICE bit two cycles after Start; one bit per clock.
// Backpressure: none downstream; a missing byte aborts (DATA_SEQ_UNDERRUN_EN) or is sent as 0x00.
module data_field_sequencer
    import data_field_sequencer_pkg::*;
#(
    parameter int LENGTH_W = 12
) (
    input  logic                     Clock,
    input  logic                     Reset,
    data_field_sequencer_if.slave    bus
);

    localparam int CNT_W = LENGTH_W + 3;

    state_t              state_q;
    state_t              state_d;
    logic [LENGTH_W-1:0] len_q;
    logic [7:0]          ndbps_q;
    logic [7:0]          sym_cnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                scr_reset_q;
    logic                done_q;

    logic                start_acc;
    logic                out_vld;
    logic                sym_wrap;
    logic                service_last;
    logic                psdu_last;
    logic                tail_last;
    logic                fetch;
    logic                underrun;
    logic [7:0]          fetch_dat;
    logic                ser_bit;
    logic                ser_last;

    // Start is ignored in the Done cycle even though the state is already IDLE.
    assign start_acc    = (state_q == ST_IDLE) && !done_q && bus.Start;
    assign service_last = (cnt_q == CNT_W'(SERVICE_BITS - 1));
    assign psdu_last    = (cnt_q == ({len_q, 3'b000} - CNT_W'(1)));
    assign tail_last    = (cnt_q == CNT_W'(TAIL_BITS - 1));
    assign sym_wrap     = out_vld && (sym_cnt_q == (ndbps_q - 8'd1));

    // A byte is requested on the last SERVICE bit and on the last bit of every PSDU byte but the final one.
    assign fetch = ((state_q == ST_SERVICE) && service_last && (len_q != '0)) ||
                   ((state_q == ST_PSDU) && ser_last && !psdu_last);

`ifdef DATA_SEQ_UNDERRUN_EN
    assign underrun  = fetch && !bus.Byte_Valid;
    assign fetch_dat = bus.Byte;
`else
    assign underrun  = 1'b0;
    assign fetch_dat = bus.Byte_Valid ? bus.Byte : 8'h00;
`endif

    data_seq_serializer u_ser (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (fetch),
        .load_dat (fetch_dat),
        .shift    (state_q == ST_PSDU),
        .bit_dat  (ser_bit),
        .last     (ser_last)
    );

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; padding ends purely on the symbol counter wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_acc) state_d = ST_SEED;
            ST_SEED:    state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (underrun)          state_d = ST_IDLE;
                else if (service_last) state_d = (len_q == '0) ? ST_TAIL : ST_PSDU;
            end
            ST_PSDU: begin
                if (underrun)       state_d = ST_IDLE;
                else if (psdu_last) state_d = ST_TAIL;
            end
            ST_TAIL:    if (tail_last) state_d = sym_wrap ? ST_IDLE : ST_PAD;
            ST_PAD:     if (sym_wrap) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode: scrambled bits everywhere except TAIL, which is forced to zero.
    always_comb begin
        out_vld       = 1'b0;
        bus.Out_Bit   = 1'b0;
        bus.Scr_Input = 1'b0;
        case (state_q)
            ST_SERVICE: begin
                out_vld     = 1'b1;
                bus.Out_Bit = bus.Scr_Output;
            end
            ST_PSDU: begin
                out_vld       = 1'b1;
                bus.Scr_Input = ser_bit;
                bus.Out_Bit   = bus.Scr_Output;
            end
            ST_TAIL: out_vld = 1'b1;
            ST_PAD: begin
                out_vld     = 1'b1;
                bus.Out_Bit = bus.Scr_Output;
            end
            default: ;
        endcase
    end

    assign bus.Out_Valid  = out_vld;
    assign bus.Byte_Ready = fetch;
    assign bus.Busy       = (state_q != ST_IDLE);
    assign bus.Done       = done_q;
    assign bus.Error      = underrun;
    assign bus.Scr_Reset  = scr_reset_q;

    // Frame parameters, scrambler re-seed strobe and the Done pulse.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            len_q       <= '0;
            ndbps_q     <= '0;
            scr_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            if (start_acc) begin
                len_q   <= bus.Length;
                ndbps_q <= bus.N_DBPS;
            end
            scr_reset_q <= (state_d == ST_SEED) || underrun;
            done_q      <= sym_wrap && ((state_q == ST_PAD) || ((state_q == ST_TAIL) && tail_last));
        end
    end

    // Per-phase bit counter, restarted on every state change.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)                                            cnt_q <= '0;
        else if ((state_d != state_q) || (state_q == ST_IDLE)) cnt_q <= '0;
        else                                                   cnt_q <= cnt_q + CNT_W'(1);
    end

    // Symbol bit counter: cleared while seeding, wraps at N_DBPS on emitted bits.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)                  sym_cnt_q <= '0;
        else if (state_q == ST_SEED) sym_cnt_q <= '0;
        else if (out_vld)            sym_cnt_q <= sym_wrap ? 8'd0 : (sym_cnt_q + 8'd1);
    end

endmodule

// File: tb/tb_data_field_sequencer.sv
// Directed bench for data_field_sequencer with a behavioural 802.11a scrambler (x^7 + x^4 + 1).
// Latency: frames are timed from the Start sample edge (cycle 0).
// Backpressure: bytes are offered every cycle; one chosen Byte_Ready can be left without a valid byte.
module tb_data_field_sequencer;

    logic Clock = 1'b0;
    logic Reset;

    data_field_sequencer_if #(.LENGTH_W(12)) bus ();

    data_field_sequencer #(.LENGTH_W(12)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // External scrambler model: re-seeds to all ones, advances every cycle otherwise.
    logic [6:0] scr_q;
    logic       ks;
    assign ks             = scr_q[6] ^ scr_q[3];
    assign bus.Scr_Output = bus.Scr_Input ^ ks;
    always_ff @(posedge Clock) begin
        if (bus.Scr_Reset) scr_q <= 7'h7F;
        else               scr_q <= {scr_q[5:0], ks};
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem   [0:127];
    logic [7:0] ref_b [0:127];
    logic       obit  [0:1023];
    logic       dbit  [0:1023];
    logic [15:0] seq_ref;
    int         n_vld, n_rdy, n_done, n_err, done_cyc, err_cyc;
    logic       scr_after_end, busy_after_end;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({bus.Busy, bus.Out_Valid, bus.Scr_Reset, bus.Byte_Ready,
                     bus.Out_Bit, bus.Scr_Input, bus.Done, bus.Error});
    endfunction

    task automatic apply_reset();
        Reset          = 1'b0;
        bus.Start      = 1'b0;
        bus.Byte_Valid = 1'b0;
        bus.Byte       = 8'h00;
        bus.Length     = '0;
        bus.N_DBPS     = 8'd0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    // Runs one frame; start_cyc pulses an extra Start, abort_cyc pulls Reset low at that cycle.
    task automatic run_frame(input int len, input logic [7:0] ndbps, input int drop_at,
                             input int start_cyc, input int abort_cyc);
        int cyc;
        int post;
        bit fin;
        n_vld = 0; n_rdy = 0; n_done = 0; n_err = 0;
        done_cyc = -1; err_cyc = -1;
        scr_after_end = 1'b0; busy_after_end = 1'b1;
        @(negedge Clock);
        bus.Start  = 1'b1;
        bus.Length = 12'(len);
        bus.N_DBPS = ndbps;
        cyc = 1; post = 0; fin = 0;
        while (cyc < 3000 && post < 2) begin
            @(negedge Clock);
            bus.Start      = (cyc == start_cyc);
            bus.Byte       = mem[n_rdy % 128];
            bus.Byte_Valid = ((n_rdy + 1) != drop_at);
            if (cyc == abort_cyc) begin
                Reset = 1'b0;
                #1;
                check("abort_outputs", out_vec(), 32);
                bus.Start = 1'b0;
                return;
            end
            #1;
            if (bus.Out_Valid && n_vld < 1024) begin
                obit[n_vld] = bus.Out_Bit;
                dbit[n_vld] = bus.Out_Bit ^ ks;
                n_vld++;
            end
            if (bus.Byte_Ready) n_rdy++;
            if (bus.Done)  begin n_done++; done_cyc = cyc; end
            if (bus.Error) begin n_err++;  err_cyc  = cyc; end
            if (fin) begin
                post++;
                if (post == 1) begin
                    scr_after_end  = bus.Scr_Reset;
                    busy_after_end = bus.Busy;
                end
            end
            if (bus.Done || bus.Error) fin = 1;
            cyc++;
        end
        bus.Start = 1'b0;
        if (!fin) check("timeout", 0, 1);
    endtask

    task automatic check_data(input int len, input int exp_bits, input int exp_rdy);
        int svc_err  = 0;
        int seq_err  = 0;
        int psdu_err = 0;
        int tail_one = 0;
        for (int i = 0; i < 16; i++) begin
            if (dbit[i] !== 1'b0) svc_err++;
            if (obit[i] !== seq_ref[15-i]) seq_err++;
        end
        for (int i = 0; i < 8 * len; i++)
            if (dbit[16+i] !== ref_b[i/8][i%8]) psdu_err++;
        for (int i = 0; i < 6; i++)
            if (obit[16 + 8*len + i] !== 1'b0) tail_one++;
        check("n_bits",     n_vld,    exp_bits);
        check("done_cycle", done_cyc, exp_bits + 2);
        check("n_done",     n_done,   1);
        check("n_error",    n_err,    0);
        check("n_ready",    n_rdy,    exp_rdy);
        check("svc_seq",    seq_err,  0);
        check("svc_zero",   svc_err,  0);
        check("psdu_data",  psdu_err, 0);
        check("tail_zero",  tail_one, 0);
        check("idle_after", int'(busy_after_end), 0);
    endtask

    initial begin
        seq_ref = 16'b0000111011110010;
        for (int i = 0; i < 128; i++) begin
            mem[i]   = 8'h00;
            ref_b[i] = 8'h00;
        end

        // Reset values, then Scr_Reset must drop on the first clock after release.
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Byte_Valid = 1'b0; bus.Byte = 8'h00;
        bus.Length = '0; bus.N_DBPS = 8'd0;
        #2;
        Reset = 1'b0;
        #1;
        check("reset_outputs", out_vec(), 32);
        apply_reset();
        check("scr_reset_release", int'(bus.Scr_Reset), 0);

        // Empty PSDU; a Start coincident with Done must not launch a frame.
        run_frame(0, 8'd24, 0, 26, 0);
        check_data(0, 24, 0);

        // Single byte 0xA5 with a Start pulse in the middle of PAD.
        apply_reset();
        mem[0] = 8'hA5; ref_b[0] = 8'hA5;
        run_frame(1, 8'd24, 0, 40, 0);
        check_data(1, 48, 1);

        // 100 random bytes at 54 Mb/s.
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            mem[i]   = 8'($urandom_range(0, 255));
            ref_b[i] = mem[i];
        end
        run_frame(100, 8'd216, 0, 0, 0);
        check_data(100, 864, 100);

        // Missing third byte of a 10-byte frame.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            mem[i]   = 8'(8'h31 + 8'(i * 7));
            ref_b[i] = mem[i];
        end
        run_frame(10, 8'd48, 3, 0, 0);
`ifdef DATA_SEQ_UNDERRUN_EN
        check("ur_n_error",   n_err,    1);
        check("ur_err_cycle", err_cyc,  33);
        check("ur_n_done",    n_done,   0);
        check("ur_n_bits",    n_vld,    32);
        check("ur_scr_reset", int'(scr_after_end),  1);
        check("ur_idle",      int'(busy_after_end), 0);
`else
        ref_b[2] = 8'h00;
        check_data(10, 144, 10);
`endif

        // Reset in the middle of PSDU, then a clean frame.
        apply_reset();
        run_frame(10, 8'd48, 0, 0, 30);
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            mem[i]   = 8'(8'hC0 ^ 8'(i * 19));
            ref_b[i] = mem[i];
        end
        run_frame(5, 8'd72, 0, 0, 0);
        check_data(5, 72, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_field_sequencer.md
# data_field_sequencer

Sequences the 802.11a PLCP DATA field through the transmit scrambler. Serializes the SERVICE, PSDU, TAIL and PAD bits, re-seeds the scrambler before each frame, and forces the six tail bits to zero after scrambling. Pads the field to an integer number of OFDM symbols. Sits between the MAC byte interface and the convolutional encoder, and emits one bit per clock with no stalls, because the scrambler advances every cycle.

## Interface
- LENGTH_W, 12, width of PSDU length in bytes (max 4095)
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle frame start; sampled only in IDLE
- Length  in  LENGTH_W  PSDU byte count, sampled with Start
- N_DBPS  in  8  data bits per OFDM symbol (24..216), sampled with Start
- Byte  in  8  PSDU byte
- Byte_Valid  in  1  Byte holds a valid byte
- Byte_Ready  out  1  byte-accept strobe; transfer when Byte_Ready & Byte_Valid
- Scr_Reset  out  1  registered, active-high re-seed to the scrambler (all ones)
- Scr_Input  out  1  bit fed to the scrambler input
- Scr_Output  in  1  scrambled bit returned by the scrambler (combinational)
- Out_Bit  out  1  DATA-field bit to the encoder
- Out_Valid  out  1  Out_Bit is valid
- Busy  out  1  a frame is in progress (not IDLE)
- Done  out  1  one-cycle pulse after the last PAD bit
- Error  out  1  one-cycle pulse on underrun abort

## Operation
- States are IDLE, SEED, SERVICE, PSDU, TAIL, PAD.
- IDLE: Start latches Length and N_DBPS, then goes to SEED. Start is ignored in every other state.
- SEED: one cycle with Scr_Reset=1, then goes to SERVICE.
- SERVICE: 16 bits, Scr_Input=0. Goes to PSDU, or to TAIL if Length=0.
- PSDU: 8·Length bits. Each byte is sent LSB first from an 8-bit shift register.
- TAIL: 6 bits, Scr_Input=0. Out_Bit is forced to 0 (not Scr_Output).
- PAD: Scr_Input=0; Out_Bit=Scr_Output. Runs until the symbol bit counter wraps, then goes to IDLE and pulses Done.
- Out_Bit = Scr_Output in SERVICE, PSDU and PAD. Out_Valid=1 in those states and in TAIL.
- Symbol bit counter:
  - cleared in SEED;
  - increments on every Out_Valid cycle and wraps from N_DBPS−1 to 0;
  - a wrap at the last TAIL bit means PAD is skipped. This cannot occur for legal N_DBPS values, but the RTL handles it.
- Byte fetch:
  - Byte_Ready=1 for exactly one cycle: the last SERVICE bit and the last bit of each PSDU byte except the final one.
  - A byte accepted there loads the shift register for the next cycle.
- Underrun: Byte_Ready=1 with Byte_Valid=0. The block pulses Error, asserts Scr_Reset next cycle, and returns to IDLE without Done.
- Bit and byte counters are sized from LENGTH_W+3 bits. No arithmetic division; padding comes only from the counter wrap.

## Timing
- Reset (Reset=0) values: state IDLE, Scr_Reset=1, Byte_Ready=0, Out_Valid=0, Out_Bit=0, Scr_Input=0, Busy=0, Done=0, Error=0.
- After reset release, Scr_Reset deasserts on the first clock.
- Frame timeline, with Start sampled at cycle 0:
  - cycle 1: SEED;
  - cycles 2–17: SERVICE bits;
  - PSDU starts at cycle 18;
  - Done is asserted in the cycle after the final PAD bit.
- Total Out_Valid cycles = N_SYM·N_DBPS, where N_SYM = ceil((22+8·Length)/N_DBPS).
- Reset asserted mid-frame aborts immediately: no Done, no Error.
- Start arriving in the same cycle as Done is ignored; the block is IDLE from the next cycle.

## Configuration
- DATA_SEQ_UNDERRUN_EN
  - Defined: underrun aborts the frame as described under Operation.
  - Undefined: a missing byte is replaced by 0x00, the frame continues to completion, and Error is tied to 0.

## Structure
- Shared package holds:
  - the state enum;
  - SERVICE_BITS=16 and TAIL_BITS=6;
  - named N_DBPS constants for 6/9/12/18/24/36/48/54 Mb/s (24, 36, 48, 72, 96, 144, 192, 216).
- One sub-module, data_seq_serializer: 8-bit load/shift register with a bit index and a last-bit flag.
- The scrambler stays external and is connected through Scr_Reset, Scr_Input and Scr_Output.

## Test plan
- Length=0, N_DBPS=24 -> 24 Out_Valid bits: 16 service + 6 zero tail + 2 pad; no Byte_Ready; Done at cycle 26.
- Length=1, N_DBPS=24, Byte=0xA5 -> 48 bits (18 pad); PSDU bits descramble to 1,0,1,0,0,1,0,1.
- Length=100, N_DBPS=216, random bytes -> 864 bits (42 pad); tail bits zero; the first 16 output bits equal the all-ones-seed scrambler sequence.
- Byte_Valid dropped at the 3rd Byte_Ready of a 10-byte frame -> Error pulse, Scr_Reset next cycle, IDLE, no Done; with the macro undefined, byte 3 is sent as 0x00 and Done fires.
- Reset=0 in the middle of PSDU -> all outputs at their reset values immediately; the next Start runs a full, correct frame.
- Start pulsed during PAD -> ignored; bit count and Done are unchanged.
